// File: rtl/victim_cache_ctrl.sv
// rtl/victim_cache_ctrl.sv - victim-cache tag-store command sequencer with FIFO victim selection
// Optional VC_PERF_CNT_EN adds saturating hit/miss/writeback counters.
module victim_cache_ctrl #(
  parameter  int TAG_WIDTH = 4,
  parameter  int NUM_WAYS  = 4,
  localparam int WAY_W     = $clog2(NUM_WAYS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_op,
  input  logic [TAG_WIDTH-1:0] req_tag,
  input  logic                 req_dirty,
  output logic                 resp_valid,
  output logic                 resp_hit,
  output logic [WAY_W-1:0]     resp_way,
  output logic                 ts_lookup_en,
  output logic                 ts_read_en,
  output logic                 ts_write_en,
  output logic                 ts_valid_clear,
  output logic                 ts_dirty_set,
  output logic [TAG_WIDTH-1:0] ts_tag,
  output logic [WAY_W-1:0]     ts_way,
  input  logic                 ts_hit,
  input  logic [WAY_W-1:0]     ts_hit_way,
  input  logic                 ts_valid_read,
  input  logic                 ts_dirty_read,
  input  logic [TAG_WIDTH-1:0] ts_tag_read,
  output logic                 wb_valid,
  input  logic                 wb_ready,
  output logic [TAG_WIDTH-1:0] wb_tag,
  output logic [WAY_W-1:0]     wb_way
`ifdef VC_PERF_CNT_EN
  ,
  output logic [15:0]          perf_hits,
  output logic [15:0]          perf_misses,
  output logic [15:0]          perf_wbs
`endif
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOOKUP, S_INVAL, S_VREAD, S_WB, S_WRITE, S_DSET, S_RESP
  } state_t;

  state_t                 r_state;
  state_t                 w_nxt;
  logic                   w_req_fire;
  logic [TAG_WIDTH-1:0]   r_tag;
  logic [WAY_W-1:0]       r_way;
  logic                   r_dirty;
  logic [WAY_W-1:0]       r_fifo_ptr;
  logic [TAG_WIDTH-1:0]   r_wb_tag;
  logic [WAY_W-1:0]       r_wb_way;
  logic                   r_req_ready;
  logic                   r_resp_valid;
  logic                   r_resp_hit;
  logic [WAY_W-1:0]       r_resp_way;
  logic                   r_lookup;
  logic                   r_read;
  logic                   r_write;
  logic                   r_vclr;
  logic                   r_dset;
  logic                   r_wb_valid;

  assign w_req_fire = req_valid & r_req_ready;

  always_comb begin
    w_nxt = r_state;
    case (r_state)
      S_IDLE:   if (w_req_fire) w_nxt = req_op ? S_VREAD : S_LOOKUP;
      S_LOOKUP: w_nxt = ts_hit ? S_INVAL : S_RESP;
      S_INVAL:  w_nxt = S_RESP;
      S_VREAD:  w_nxt = (ts_valid_read & ts_dirty_read) ? S_WB : S_WRITE;
      S_WB:     if (wb_ready) w_nxt = S_WRITE;
      S_WRITE:  w_nxt = r_dirty ? S_DSET : S_RESP;
      S_DSET:   w_nxt = S_RESP;
      S_RESP:   w_nxt = S_IDLE;
      default:  w_nxt = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so every strobe is a clean register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_tag        <= '0;
      r_way        <= '0;
      r_dirty      <= 1'b0;
      r_fifo_ptr   <= '0;
      r_wb_tag     <= '0;
      r_wb_way     <= '0;
      r_req_ready  <= 1'b0;
      r_resp_valid <= 1'b0;
      r_resp_hit   <= 1'b0;
      r_resp_way   <= '0;
      r_lookup     <= 1'b0;
      r_read       <= 1'b0;
      r_write      <= 1'b0;
      r_vclr       <= 1'b0;
      r_dset       <= 1'b0;
      r_wb_valid   <= 1'b0;
    end else begin
      r_state <= w_nxt;
      case (r_state)
        S_IDLE: begin
          if (w_req_fire) begin
            r_tag   <= req_tag;
            r_dirty <= req_dirty;
            r_way   <= r_fifo_ptr;
          end
        end
        S_LOOKUP: begin
          if (ts_hit) r_way <= ts_hit_way;
        end
        S_VREAD: begin
          r_wb_tag <= ts_tag_read;
          r_wb_way <= r_way;
        end
        S_WRITE: begin
          r_fifo_ptr <= r_fifo_ptr + {{(WAY_W-1){1'b0}}, 1'b1};
        end
        default: ;
      endcase
      r_req_ready  <= (w_nxt == S_IDLE);
      r_lookup     <= (w_nxt == S_LOOKUP);
      r_read       <= (w_nxt == S_VREAD);
      r_write      <= (w_nxt == S_WRITE);
      r_vclr       <= (w_nxt == S_INVAL);
      r_dset       <= (w_nxt == S_DSET);
      r_wb_valid   <= (w_nxt == S_WB);
      r_resp_valid <= (w_nxt == S_RESP);
      // Only the INVAL path reaches RESP with a hit; a LOOKUP->RESP hop is a miss.
      r_resp_hit   <= (w_nxt == S_RESP) && (r_state == S_INVAL);
      r_resp_way   <= ((w_nxt == S_RESP) && (r_state != S_LOOKUP)) ? r_way : '0;
    end
  end

  assign req_ready      = r_req_ready;
  assign resp_valid     = r_resp_valid;
  assign resp_hit       = r_resp_hit;
  assign resp_way       = r_resp_way;
  assign ts_lookup_en   = r_lookup;
  assign ts_read_en     = r_read;
  assign ts_write_en    = r_write;
  assign ts_valid_clear = r_vclr;
  assign ts_dirty_set   = r_dset;
  assign ts_tag         = r_tag;
  assign ts_way         = r_way;
  assign wb_valid       = r_wb_valid;
  assign wb_tag         = r_wb_tag;
  assign wb_way         = r_wb_way;

`ifdef VC_PERF_CNT_EN
  logic [15:0] r_perf_hits;
  logic [15:0] r_perf_misses;
  logic [15:0] r_perf_wbs;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_perf_hits   <= '0;
      r_perf_misses <= '0;
      r_perf_wbs    <= '0;
    end else begin
      if (r_state == S_LOOKUP && ts_hit && r_perf_hits != 16'hFFFF)
        r_perf_hits <= r_perf_hits + 16'd1;
      if (r_state == S_LOOKUP && !ts_hit && r_perf_misses != 16'hFFFF)
        r_perf_misses <= r_perf_misses + 16'd1;
      if (r_state == S_WB && wb_ready && r_perf_wbs != 16'hFFFF)
        r_perf_wbs <= r_perf_wbs + 16'd1;
    end
  end

  assign perf_hits   = r_perf_hits;
  assign perf_misses = r_perf_misses;
  assign perf_wbs    = r_perf_wbs;
`endif

endmodule

// File: tb/tb_victim_cache_ctrl.sv
// tb/tb_victim_cache_ctrl.sv - self-checking bench for victim_cache_ctrl with a behavioural tag store
module tb_victim_cache_ctrl;
  localparam int TW = 4;
  localparam int NW = 4;
  localparam int WW = 2;

  logic clk = 1'b0;
  logic rst;
  logic req_valid, req_ready, req_op, req_dirty;
  logic [TW-1:0] req_tag;
  logic resp_valid, resp_hit;
  logic [WW-1:0] resp_way;
  logic ts_lookup_en, ts_read_en, ts_write_en, ts_valid_clear, ts_dirty_set;
  logic [TW-1:0] ts_tag;
  logic [WW-1:0] ts_way;
  logic ts_hit;
  logic [WW-1:0] ts_hit_way;
  logic ts_valid_read, ts_dirty_read;
  logic [TW-1:0] ts_tag_read;
  logic wb_valid, wb_ready;
  logic [TW-1:0] wb_tag;
  logic [WW-1:0] wb_way;
`ifdef VC_PERF_CNT_EN
  logic [15:0] perf_hits, perf_misses, perf_wbs;
`endif

  always #5 clk = ~clk;

  victim_cache_ctrl #(.TAG_WIDTH(TW), .NUM_WAYS(NW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_tag(req_tag), .req_dirty(req_dirty),
    .resp_valid(resp_valid), .resp_hit(resp_hit), .resp_way(resp_way),
    .ts_lookup_en(ts_lookup_en), .ts_read_en(ts_read_en), .ts_write_en(ts_write_en),
    .ts_valid_clear(ts_valid_clear), .ts_dirty_set(ts_dirty_set),
    .ts_tag(ts_tag), .ts_way(ts_way), .ts_hit(ts_hit), .ts_hit_way(ts_hit_way),
    .ts_valid_read(ts_valid_read), .ts_dirty_read(ts_dirty_read), .ts_tag_read(ts_tag_read),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_tag(wb_tag), .wb_way(wb_way)
`ifdef VC_PERF_CNT_EN
    , .perf_hits(perf_hits), .perf_misses(perf_misses), .perf_wbs(perf_wbs)
`endif
  );

  // Behavioural tag store: combinational lookup/read, strobes applied at the clock edge.
  logic          m_valid [NW];
  logic          m_dirty [NW];
  logic [TW-1:0] m_tag   [NW];

  always_comb begin
    ts_hit = 1'b0;
    ts_hit_way = '0;
    for (int i = 0; i < NW; i++)
      if (m_valid[i] && m_tag[i] == ts_tag) begin
        ts_hit = 1'b1;
        ts_hit_way = WW'(i);
      end
  end
  assign ts_valid_read = m_valid[ts_way];
  assign ts_dirty_read = m_dirty[ts_way];
  assign ts_tag_read   = m_tag[ts_way];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NW; i++) begin
        m_valid[i] <= 1'b0;
        m_dirty[i] <= 1'b0;
        m_tag[i]   <= '0;
      end
    end else if (ts_write_en) begin
      m_valid[ts_way] <= 1'b1;
      m_dirty[ts_way] <= 1'b0;
      m_tag[ts_way]   <= ts_tag;
    end else if (ts_valid_clear) begin
      m_valid[ts_way] <= 1'b0;
    end else if (ts_dirty_set) begin
      m_dirty[ts_way] <= 1'b1;
    end
  end

  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
  endtask

  typedef struct {
    logic          hit;
    logic [WW-1:0] way;
    int            lat;
  } exp_t;
  exp_t sb_q[$];

  int m_ptr, m_hits, m_misses, m_wbs;
  int c_look, c_read, c_write, c_clr, c_dset;
  logic [WW-1:0] e_way;
  logic [TW-1:0] e_tag;

  always @(negedge clk) begin
    if (!rst) begin
      automatic int ns = int'(ts_lookup_en) + int'(ts_read_en) + int'(ts_write_en)
                       + int'(ts_valid_clear) + int'(ts_dirty_set);
      check("one_strobe", ns <= 1, 1);
      c_look  += int'(ts_lookup_en);
      c_read  += int'(ts_read_en);
      c_write += int'(ts_write_en);
      c_clr   += int'(ts_valid_clear);
      c_dset  += int'(ts_dirty_set);
      if (ts_write_en) begin
        check("write_way", ts_way, e_way);
        check("write_tag", ts_tag, e_tag);
      end
      if (ts_valid_clear) check("clear_way", ts_way, e_way);
      if (ts_dirty_set)   check("dset_way", ts_way, e_way);
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    wb_ready = 1'b0;
    req_valid = 1'b0;
    m_ptr = 0; m_hits = 0; m_misses = 0; m_wbs = 0;
    sb_q.delete();
    repeat (2) @(negedge clk);
    check("rst_req_ready", req_ready, 0);
    check("rst_resp_valid", resp_valid, 0);
    check("rst_wb_valid", wb_valid, 0);
    check("rst_write_en", ts_write_en, 0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_req_ready", req_ready, 1);
  endtask

  task automatic send(input logic op, input logic [TW-1:0] tag, input logic dirty, input int hold);
    exp_t e;
    logic ewb;
    logic [TW-1:0] ewb_tag;
    int n, h, nwb;
    bit got;
    e.hit = 1'b0; e.way = '0; ewb = 1'b0; ewb_tag = '0;
    if (!op) begin
      for (int i = 0; i < NW; i++)
        if (m_valid[i] && m_tag[i] == tag) begin
          e.hit = 1'b1;
          e.way = WW'(i);
        end
      e.lat = e.hit ? 3 : 2;
      if (e.hit) m_hits++; else m_misses++;
    end else begin
      e.way = WW'(m_ptr);
      ewb = m_valid[m_ptr] && m_dirty[m_ptr];
      ewb_tag = m_tag[m_ptr];
      e.lat = 3 + (dirty ? 1 : 0) + (ewb ? hold + 1 : 0);
      m_ptr = (m_ptr + 1) % NW;
      if (ewb) m_wbs++;
    end
    sb_q.push_back(e);
    e_way = e.way; e_tag = tag;
    c_look = 0; c_read = 0; c_write = 0; c_clr = 0; c_dset = 0;
    got = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      got = req_ready;
    end
    check("req_ready_wait", got, 1);
    if (!got) return;
    req_valid = 1'b1; req_op = op; req_tag = tag; req_dirty = dirty;
    @(posedge clk);
    #1 req_valid = 1'b0;
    h = hold; n = 0; nwb = 0; got = 1'b0;
    while (!got && n < 40) begin
      @(negedge clk);
      n++;
      if (wb_valid) begin
        nwb++;
        check("wb_tag", wb_tag, ewb_tag);
        check("wb_way", wb_way, e.way);
        if (h > 0) begin
          h--;
          wb_ready = 1'b0;
          check("no_write_during_wb", ts_write_en, 0);
        end else wb_ready = 1'b1;
      end else wb_ready = 1'b0;
      if (resp_valid) got = 1'b1;
    end
    check("resp_seen", got, 1);
    if (got) begin
      e = sb_q.pop_front();
      check("resp_latency", n, e.lat);
      check("resp_hit", resp_hit, e.hit);
      check("resp_way", resp_way, e.way);
    end
    check("wb_cycles", nwb, ewb ? hold + 1 : 0);
    check("lookup_cnt", c_look, op ? 0 : 1);
    check("read_cnt", c_read, op ? 1 : 0);
    check("write_cnt", c_write, op ? 1 : 0);
    check("clear_cnt", c_clr, (!op && e.hit) ? 1 : 0);
    check("dset_cnt", c_dset, (op && dirty) ? 1 : 0);
    @(negedge clk);
    check("resp_pulse", resp_valid, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    rst = 1'b1;
    req_valid = 1'b0; req_op = 1'b0; req_tag = '0; req_dirty = 1'b0; wb_ready = 1'b0;
    do_reset();

    send(1'b1, 4'h3, 1'b0, 0);
    send(1'b0, 4'h3, 1'b0, 0);
    send(1'b0, 4'h3, 1'b0, 0);
    send(1'b0, 4'hA, 1'b0, 0);

    do_reset();
    for (int t = 0; t < 4; t++) send(1'b1, TW'(t), 1'b1, 0);
    send(1'b1, 4'h4, 1'b1, 3);
    send(1'b0, 4'h4, 1'b0, 0);
    send(1'b0, 4'h2, 1'b0, 0);
    send(1'b0, 4'h4, 1'b0, 0);
    send(1'b0, 4'hA, 1'b0, 0);
    send(1'b0, 4'hB, 1'b0, 0);
`ifdef VC_PERF_CNT_EN
    check("perf_hits", perf_hits, m_hits);
    check("perf_misses", perf_misses, m_misses);
    check("perf_wbs", perf_wbs, m_wbs);
`endif

    // Way 1 still holds dirty tag 1: start an insert and reset while the writeback waits.
    @(negedge clk);
    check("t5_ready", req_ready, 1);
    req_valid = 1'b1; req_op = 1'b1; req_tag = 4'h7; req_dirty = 1'b0;
    @(posedge clk);
    #1 req_valid = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 10 && !seen; k++) begin
      @(negedge clk);
      seen = wb_valid;
    end
    check("t5_wb_seen", seen, 1);
    check("t5_wb_tag", wb_tag, 4'h1);
    rst = 1'b1;
    #1;
    check("t5_wb_drop", wb_valid, 0);
    check("t5_ready_in_rst", req_ready, 0);
    do_reset();
    send(1'b1, 4'h9, 1'b0, 0);
    send(1'b0, 4'h9, 1'b0, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
